// File: rtl/hs_pack_if.sv
// Valid/ready bundle for hs_pack: narrow beat side (valid_in/data_in/last_in/ready_in)
// and wide word side (valid_out/data_out/cnt_out/last_out/ready_out).
interface hs_pack_if #(
  parameter int DATA_WD = 32,
  parameter int RATIO   = 4
);
  localparam int CNT_WD = $clog2(RATIO) + 1;

  logic                       valid_in;
  logic [DATA_WD-1:0]         data_in;
  logic                       last_in;
  logic                       ready_in;
  logic                       valid_out;
  logic [DATA_WD*RATIO-1:0]   data_out;
  logic [CNT_WD-1:0]          cnt_out;
  logic                       last_out;
  logic                       ready_out;

  modport slave (
    input  valid_in, data_in, last_in, ready_out,
    output ready_in, valid_out, data_out, cnt_out, last_out
  );

  modport master (
    output valid_in, data_in, last_in, ready_out,
    input  ready_in, valid_out, data_out, cnt_out, last_out
  );
endinterface

// File: rtl/hs_pack.sv
// Packs RATIO narrow beats into one registered wide word (first beat in lane 0).
// `HS_PACK_LAST_EN enables early flush on last_in with zero-filled upper lanes.
module hs_pack #(
  parameter int DATA_WD = 32,
  parameter int RATIO   = 4
) (
  input  logic      clk,
  input  logic      rst,
  hs_pack_if.slave  bus
);
  localparam int CNT_WD = $clog2(RATIO) + 1;
  localparam int IDX_WD = $clog2(RATIO);
  localparam int ACC_WD = DATA_WD * (RATIO - 1);
  localparam int OUT_WD = DATA_WD * RATIO;
  localparam logic [IDX_WD-1:0] IDX_MAX = IDX_WD'(RATIO - 1);

  logic [IDX_WD-1:0] idx_r, idx_nxt_s;
  logic [ACC_WD-1:0] acc_r, acc_nxt_s;
  logic [OUT_WD-1:0] data_r, data_nxt_s;
  logic [CNT_WD-1:0] cnt_r, cnt_nxt_s;
  logic              last_r, last_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic              ready_in_s, fire_in_s, fire_out_s, done_s, flush_s;

`ifdef HS_PACK_LAST_EN
  // Lanes below idx come from the accumulator, lane idx is the beat, lanes above are zero.
  function automatic logic [OUT_WD-1:0] pack_word(
    input logic [ACC_WD-1:0]  acc,
    input logic [DATA_WD-1:0] beat,
    input logic [IDX_WD-1:0]  idx
  );
    logic [OUT_WD-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (IDX_WD'(k) == idx) begin
        w[k*DATA_WD +: DATA_WD] = beat;
      end else if (IDX_WD'(k) < idx) begin
        w[k*DATA_WD +: DATA_WD] = acc[k*DATA_WD +: DATA_WD];
      end else begin
        w[k*DATA_WD +: DATA_WD] = '0;
      end
    end
    if (idx == IDX_MAX) begin
      w[(RATIO-1)*DATA_WD +: DATA_WD] = beat;
    end else begin
      w[(RATIO-1)*DATA_WD +: DATA_WD] = '0;
    end
    return w;
  endfunction

  assign flush_s = bus.last_in;
`else
  logic unused_last_s;
  assign unused_last_s = bus.last_in;
  assign flush_s       = 1'b0;
`endif

  assign ready_in_s = !valid_r || bus.ready_out;
  assign fire_in_s  = bus.valid_in && ready_in_s;
  assign fire_out_s = valid_r && bus.ready_out;
  assign done_s     = fire_in_s && ((idx_r == IDX_MAX) || flush_s);

  // Next-state for the lane index, accumulator and output word register.
  always_comb begin
    idx_nxt_s   = idx_r;
    acc_nxt_s   = acc_r;
    data_nxt_s  = data_r;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    valid_nxt_s = valid_r;

    if (done_s) begin
`ifdef HS_PACK_LAST_EN
      data_nxt_s = pack_word(acc_r, bus.data_in, idx_r);
      cnt_nxt_s  = CNT_WD'(idx_r) + CNT_WD'(1);
      last_nxt_s = flush_s;
`else
      data_nxt_s = {bus.data_in, acc_r};
      cnt_nxt_s  = CNT_WD'(RATIO);
      last_nxt_s = 1'b0;
`endif
      valid_nxt_s = 1'b1;
    end else if (fire_out_s) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end

    if (done_s) begin
      idx_nxt_s = '0;
      acc_nxt_s = '0;
    end else if (fire_in_s) begin
      idx_nxt_s = idx_r + IDX_WD'(1);
      for (int k = 0; k < RATIO - 1; k++) begin
        if (IDX_WD'(k) == idx_r) begin
          acc_nxt_s[k*DATA_WD +: DATA_WD] = bus.data_in;
        end else begin
          acc_nxt_s[k*DATA_WD +: DATA_WD] = acc_r[k*DATA_WD +: DATA_WD];
        end
      end
    end else begin
      idx_nxt_s = idx_r;
      acc_nxt_s = acc_r;
    end
  end

  // State registers with synchronous reset; a pending word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r   <= '0;
      acc_r   <= '0;
      data_r  <= '0;
      cnt_r   <= '0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      idx_r   <= idx_nxt_s;
      acc_r   <= acc_nxt_s;
      data_r  <= data_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign bus.ready_in  = ready_in_s;
  assign bus.valid_out = valid_r;
  assign bus.data_out  = data_r;
  assign bus.cnt_out   = cnt_r;
  assign bus.last_out  = last_r;
endmodule

// File: tb/tb_hs_pack.sv
// Directed table-driven bench for hs_pack (DATA_WD=32, RATIO=4); each row drives one
// cycle of inputs and lists the outputs expected in that same cycle before the edge.
module tb_hs_pack;
  localparam int DATA_WD = 32;
  localparam int RATIO   = 4;

  typedef struct {
    logic         rst;
    logic         valid;
    logic [31:0]  data;
    logic         last;
    logic         ready_out;
    logic         e_ready_in;
    logic         e_valid;
    logic [127:0] e_data;
    logic [2:0]   e_cnt;
    logic         e_last;
  } vec_t;

  localparam logic [127:0] W0 = 128'h0;
  localparam logic [127:0] W1 = {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011};
  localparam logic [127:0] W2 = {32'h00000088, 32'h00000077, 32'h00000066, 32'h00000055};
  localparam logic [127:0] W3 = {32'h000000CC, 32'h000000BB, 32'h000000AA, 32'h00000099};
  localparam logic [127:0] W4 = {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001};
  localparam logic [127:0] W5 = {32'h00000008, 32'h00000007, 32'h00000006, 32'h00000005};

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [127:0] prev_w;
  logic         prev_last;
  vec_t tbl [29];

  hs_pack_if #(.DATA_WD(DATA_WD), .RATIO(RATIO)) bus ();

  hs_pack #(.DATA_WD(DATA_WD), .RATIO(RATIO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d, input logic l,
                              input logic ro, input logic eri, input logic evo,
                              input logic [127:0] edo, input logic [2:0] ecnt, input logic elast);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.last = l; t.ready_out = ro;
    t.e_ready_in = eri; t.e_valid = evo; t.e_data = edo; t.e_cnt = ecnt; t.e_last = elast;
    return t;
  endfunction

  task automatic check(input string what, input int n, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", what, n, got, want);
    end
  endtask

  task automatic step(input vec_t v, input string tag, input int n);
    rst           = v.rst;
    bus.valid_in  = v.valid;
    bus.data_in   = v.data;
    bus.last_in   = v.last;
    bus.ready_out = v.ready_out;
    #4;
    check({tag, ".ready_in"},  n, 128'(bus.ready_in),  128'(v.e_ready_in));
    check({tag, ".valid_out"}, n, 128'(bus.valid_out), 128'(v.e_valid));
    check({tag, ".data_out"},  n, bus.data_out,        v.e_data);
    check({tag, ".cnt_out"},   n, 128'(bus.cnt_out),   128'(v.e_cnt));
    check({tag, ".last_out"},  n, 128'(bus.last_out),  128'(v.e_last));
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // basic word, valid for one cycle
    tbl[0]  = mk(1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b1, W1, 3'd4, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, W1, 3'd4, 1'b0);
    // word completes with ready_out low, then 5 stalled cycles holding beat 0x99
    tbl[6]  = mk(1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, W1, 3'd4, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 32'h66, 1'b0, 1'b0, 1'b1, 1'b0, W1, 3'd4, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 1'b0, W1, 3'd4, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 32'h88, 1'b0, 1'b0, 1'b1, 1'b0, W1, 3'd4, 1'b0);
    for (int i = 10; i < 15; i++)
      tbl[i] = mk(1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 1'b1, W2, 3'd4, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 32'h99, 1'b0, 1'b1, 1'b1, 1'b1, W2, 3'd4, 1'b0);
    tbl[16] = mk(1'b0, 1'b1, 32'hAA, 1'b0, 1'b1, 1'b1, 1'b0, W2, 3'd4, 1'b0);
    tbl[17] = mk(1'b0, 1'b1, 32'hBB, 1'b0, 1'b1, 1'b1, 1'b0, W2, 3'd4, 1'b0);
    tbl[18] = mk(1'b0, 1'b1, 32'hCC, 1'b0, 1'b1, 1'b1, 1'b0, W2, 3'd4, 1'b0);
    // eight continuous beats, ready_in never drops
    tbl[19] = mk(1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1, W3, 3'd4, 1'b0);
    tbl[20] = mk(1'b0, 1'b1, 32'h2, 1'b0, 1'b1, 1'b1, 1'b0, W3, 3'd4, 1'b0);
    tbl[21] = mk(1'b0, 1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0, W3, 3'd4, 1'b0);
    tbl[22] = mk(1'b0, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, W3, 3'd4, 1'b0);
    tbl[23] = mk(1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 1'b1, W4, 3'd4, 1'b0);
    tbl[24] = mk(1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 1'b1, 1'b0, W4, 3'd4, 1'b0);
    tbl[25] = mk(1'b0, 1'b1, 32'h7, 1'b0, 1'b1, 1'b1, 1'b0, W4, 3'd4, 1'b0);
    tbl[26] = mk(1'b0, 1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, W4, 3'd4, 1'b0);
    tbl[27] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, W5, 3'd4, 1'b0);
    tbl[28] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0);

    rst           = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = 32'h0;
    bus.last_in   = 1'b0;
    bus.ready_out = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++)
      step(tbl[i], "main", i);

`ifdef HS_PACK_LAST_EN
    step(mk(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0), "last", 0);
    step(mk(1'b0, 1'b1, 32'hB, 1'b1, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0), "last", 1);
    step(mk(1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b1, 128'h0000000B_0000000A, 3'd2, 1'b1), "last", 2);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 128'h0000000C, 3'd1, 1'b1), "last", 3);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0000000C, 3'd1, 1'b1), "last", 4);
    step(mk(1'b0, 1'b1, 32'hE, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0000000C, 3'd1, 1'b1), "last", 5);
    step(mk(1'b0, 1'b1, 32'hF, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0000000C, 3'd1, 1'b1), "last", 6);
    step(mk(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0000000C, 3'd1, 1'b1), "last", 7);
    step(mk(1'b0, 1'b1, 32'h12, 1'b1, 1'b1, 1'b1, 1'b0, 128'h0000000C, 3'd1, 1'b1), "last", 8);
    prev_w    = {32'h12, 32'h10, 32'h0F, 32'h0E};
    prev_last = 1'b1;
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, prev_w, 3'd4, 1'b1), "last", 9);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, prev_w, 3'd4, 1'b1), "last", 10);
`else
    step(mk(1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0), "last", 0);
    step(mk(1'b0, 1'b1, 32'hB, 1'b1, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0), "last", 1);
    step(mk(1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0), "last", 2);
    step(mk(1'b0, 1'b1, 32'hD, 1'b1, 1'b1, 1'b1, 1'b0, W5, 3'd4, 1'b0), "last", 3);
    prev_w    = {32'h0D, 32'h0C, 32'h0B, 32'h0A};
    prev_last = 1'b0;
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, prev_w, 3'd4, 1'b0), "last", 4);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, prev_w, 3'd4, 1'b0), "last", 5);
`endif

    // two beats accepted, reset pulse, then a clean word 4_3_2_1
    step(mk(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1, 1'b0, prev_w, 3'd4, prev_last), "rst", 0);
    step(mk(1'b0, 1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, prev_w, 3'd4, prev_last), "rst", 1);
    step(mk(1'b1, 1'b1, 32'h77, 1'b0, 1'b1, 1'b1, 1'b0, prev_w, 3'd4, prev_last), "rst", 2);
    step(mk(1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0), "rst", 3);
    step(mk(1'b0, 1'b1, 32'h2, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0), "rst", 4);
    step(mk(1'b0, 1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0), "rst", 5);
    step(mk(1'b0, 1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, W0, 3'd0, 1'b0), "rst", 6);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, W4, 3'd4, 1'b0), "rst", 7);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, W4, 3'd4, 1'b0), "rst", 8);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, W4, 3'd4, 1'b0), "rst", 9);
    step(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, W4, 3'd4, 1'b0), "rst", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
